// File: rtl/neo_zmc_banker.sv
// ZMC-style M1 bank controller: four window bank registers loaded by SDRD0 port reads,
// translating SDA into extended ROM address bits MA. Optional readback: ZMC_READBACK_EN.
module neo_zmc_banker #(
  parameter int unsigned       BANK_W    = 8,
  parameter logic [BANK_W-1:0] BANK_MASK = 8'hFF,
  parameter logic [BANK_W-1:0] RST_B0    = 8'h02,
  parameter logic [BANK_W-1:0] RST_B1    = 8'h06,
  parameter logic [BANK_W-1:0] RST_B2    = 8'h0E,
  parameter logic [BANK_W-1:0] RST_B3    = 8'h1E
) (
  input  logic              CLK_24M,
  input  logic              nRESET,
  input  logic              SDRD0,
  input  logic [15:0]       SDA,
  output logic [BANK_W+2:0] MA,
  output logic              BANK_UPD,
  output logic [7:0]        SDD_OUT,
  output logic              SDD_OE
);

  localparam int unsigned MA_W = BANK_W + 3;

  logic              s1, s2, s3;
  logic [7:0]        shadow_val;
  logic [1:0]        shadow_win;
  logic [BANK_W-1:0] bank [4];
  logic              commit;
  logic [BANK_W-1:0] commit_val;
  logic              unused_sda;

  assign commit     = s2 & ~s3;
  assign commit_val = BANK_W'(shadow_val) & BANK_MASK;
  assign BANK_UPD   = commit;
  assign unused_sda = ^SDA[7:2];

  // s1/s2 synchronise the strobe; s3 lets each synchronised rising edge commit once.
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= SDRD0;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // SDA is stable while the strobe is high, so sampling it raw is safe.
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      shadow_val <= 8'h00;
      shadow_win <= 2'b00;
    end else if (SDRD0) begin
      shadow_val <= SDA[15:8];
      shadow_win <= SDA[1:0];
    end
  end

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      bank[0] <= RST_B0 & BANK_MASK;
      bank[1] <= RST_B1 & BANK_MASK;
      bank[2] <= RST_B2 & BANK_MASK;
      bank[3] <= RST_B3 & BANK_MASK;
    end else if (commit) begin
      bank[shadow_win] <= commit_val;
    end
  end

  always_comb begin
    MA = MA_W'(SDA[15:11]);
    if (SDA[15:14] == 2'b10) begin
      MA = {bank[0], SDA[13:11]};
    end else if (SDA[15:13] == 3'b110) begin
      MA = MA_W'({bank[1], SDA[12:11]});
    end else if (SDA[15:12] == 4'b1110) begin
      MA = MA_W'({bank[2], SDA[11]});
    end else if (SDA[15:11] == 5'b11110) begin
      MA = MA_W'(bank[3]);
    end
  end

`ifdef ZMC_READBACK_EN
  logic [7:0] rb_hold;

  // Keep the pre-commit value visible for the rest of the s2 high phase.
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      rb_hold <= 8'h00;
    end else if (commit) begin
      rb_hold <= 8'(bank[shadow_win]);
    end
  end

  assign SDD_OE  = s2;
  assign SDD_OUT = !s2 ? 8'h00 : (commit ? 8'(bank[shadow_win]) : rb_hold);
`else
  assign SDD_OE  = 1'b0;
  assign SDD_OUT = 8'h00;
`endif

endmodule
